// File: rtl/zero_one_pkg.sv
// zero_one_pkg: pattern mode codes and FSM state encoding shared by the
// zero/one pattern generator and its beat counter.
`default_nettype none

package zero_one_pkg;

   localparam logic [1:0] MODE_ZERO = 2'b00;
   localparam logic [1:0] MODE_ONE  = 2'b01;
   localparam logic [1:0] MODE_ALT  = 2'b10;
   localparam logic [1:0] MODE_WALK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage : zero_one_pkg

`default_nettype wire

// File: rtl/zop_beat_counter.sv
// zop_beat_counter: beat index k, walking-one position (mod WIDTH) and
// look-ahead values for the beat that follows the current one.
`default_nettype none

module zop_beat_counter #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       advance,
   input  logic [LEN_W-1:0]           len_lat,
   output logic [$clog2(WIDTH)-1:0]   pos_next,
   output logic                       odd_next,
   output logic                       last_next
);

   localparam int                 POS_W   = $clog2(WIDTH);
   localparam logic [POS_W-1:0]   POS_MAX = POS_W'(WIDTH - 1);

   logic [LEN_W-1:0] k;
   logic [LEN_W-1:0] k_inc;
   logic [POS_W-1:0] pos;

   assign k_inc = k + LEN_W'(1);

   // Outputs describe beat k+1 so the top can register the next word
   // in the same cycle the current beat is accepted.
   always_comb begin
      pos_next  = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
      odd_next  = k_inc[0];
      last_next = (k_inc == (len_lat - LEN_W'(1)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k   <= '0;
         pos <= '0;
      end else if (clear) begin
         k   <= '0;
         pos <= '0;
      end else if (advance) begin
         k   <= k_inc;
         pos <= pos_next;
      end
   end

endmodule : zop_beat_counter

`default_nettype wire

// File: rtl/zero_one_pattern_gen.sv
// zero_one_pattern_gen: emits bursts of all-zero, all-one, alternating or
// walking-one words over valid/ready, with last marker and done pulse.
`default_nettype none

module zero_one_pattern_gen
   import zero_one_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [LEN_W-1:0] len,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int               POS_W   = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE_HOT = WIDTH'(1);

   state_t           state, state_nxt;
   logic [1:0]       mode_q, mode_nxt;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt, last_nxt, busy_nxt, done_nxt;
   logic             clear, advance;
   logic [POS_W-1:0] pos_next;
   logic             odd_next, last_next;

   function automatic logic [WIDTH-1:0] beat_word(input logic [1:0]       m,
                                                  input logic             odd,
                                                  input logic [POS_W-1:0] p);
      logic [WIDTH-1:0] w;
      case (m)
         MODE_ZERO: w = '0;
         MODE_ONE:  w = '1;
         MODE_ALT:  w = odd ? '1 : '0;
         MODE_WALK: w = ONE_HOT << p;
         default:   w = '0;
      endcase
      return w;
   endfunction

   zop_beat_counter #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_beat_counter (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .advance   (advance),
      .len_lat   (len_q),
      .pos_next  (pos_next),
      .odd_next  (odd_next),
      .last_next (last_next)
   );

   // Every output is computed one cycle ahead and registered, so ready
   // only ever reaches flops.
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      len_nxt   = len_q;
      data_nxt  = data_out;
      valid_nxt = valid;
      last_nxt  = last;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      clear     = 1'b0;
      advance   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               mode_nxt = mode;
               len_nxt  = len;
               clear    = 1'b1;
               busy_nxt = 1'b1;
               if (len != '0) begin
                  state_nxt = ST_SEND;
                  valid_nxt = 1'b1;
                  data_nxt  = beat_word(mode, 1'b0, '0);
                  last_nxt  = (len == LEN_W'(1));
               end else begin
                  state_nxt = ST_FIN;
                  done_nxt  = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (ready) begin
               if (last) begin
                  state_nxt = ST_FIN;
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  data_nxt  = '0;
                  done_nxt  = 1'b1;
               end else begin
                  advance  = 1'b1;
                  data_nxt = beat_word(mode_q, odd_next, pos_next);
                  last_nxt = last_next;
               end
            end
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            data_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_ZERO;
         len_q    <= '0;
         data_out <= '0;
         valid    <= 1'b0;
         last     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_nxt;
         len_q    <= len_nxt;
         data_out <= data_nxt;
         valid    <= valid_nxt;
         last     <= last_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

endmodule : zero_one_pattern_gen

`default_nettype wire

// File: tb/tb_zero_one_pattern_gen.sv
// Self-checking bench for zero_one_pattern_gen: directed scenarios plus
// randomized bursts checked against a word-list model of each burst.
`default_nettype none

module tb_zero_one_pattern_gen;

   localparam int WIDTH = 8;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [LEN_W-1:0] len;
   logic [WIDTH-1:0] data_out;
   logic             valid;
   logic             ready;
   logic             last;
   logic             busy;
   logic             done;

   int vectors = 0;
   int miscompares = 0;

   zero_one_pattern_gen #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .len      (len),
      .data_out (data_out),
      .valid    (valid),
      .ready    (ready),
      .last     (last),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected word for beat k of a burst.
   function automatic logic [WIDTH-1:0] model_word(input logic [1:0] m, input int k);
      logic [WIDTH-1:0] w;
      case (m)
         2'b00: w = '0;
         2'b01: w = '1;
         2'b10: w = (k % 2 == 1) ? '1 : '0;
         default: begin
            w = '0;
            w[k % WIDTH] = 1'b1;
         end
      endcase
      return w;
   endfunction

   // rmode: 0 ready held high, 1 ready pattern 1,0,0,..., 2 random ready.
   task automatic drive_burst(input logic [1:0] m, input int l, input int rmode);
      int k;
      int cyc;
      logic r;
      start = 1'b1;
      mode  = m;
      len   = LEN_W'(l);
      tick();
      start = 1'b0;
      mode  = 2'($urandom);
      len   = LEN_W'($urandom);
      if (l == 0) begin
         vectors++;
         if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL len0_done: valid=%b done=%b busy=%b required 0 1 1", valid, done, busy);
         end
         tick();
         vectors++;
         if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_idle: valid=%b done=%b busy=%b required 0 0 0", valid, done, busy);
         end
         return;
      end
      k = 0;
      cyc = 0;
      while (k < l && cyc < 400) begin
         case (rmode)
            0: r = 1'b1;
            1: r = (cyc % 3 == 0);
            default: r = 1'($urandom);
         endcase
         vectors++;
         if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
             data_out !== model_word(m, k) || last !== (k == l - 1)) begin
            miscompares++;
            $display("FAIL beat m=%0d k=%0d: valid=%b busy=%b done=%b data=%h last=%b required 1 1 0 %h %b",
                     m, k, valid, busy, done, data_out, last, model_word(m, k), (k == l - 1));
         end
         ready = r;
         if (r) k++;
         tick();
         cyc++;
      end
      ready = 1'b0;
      vectors++;
      if (k != l) begin
         miscompares++;
         $display("FAIL beat_count: got %0d beats required %0d", k, l);
      end
      vectors++;
      if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL burst_done: valid=%b done=%b busy=%b required 0 1 1", valid, done, busy);
      end
      tick();
      vectors++;
      if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL burst_idle: valid=%b done=%b busy=%b required 0 0 0", valid, done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 2'b00; len = '0; ready = 1'b0;
      #1;
      vectors++;
      if ({data_out, valid, last, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: data=%h valid=%b last=%b busy=%b done=%b required all 0",
                  data_out, valid, last, busy, done);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_all_one();
      drive_burst(2'b01, 3, 0);
   endtask

   task automatic test_walk();
      drive_burst(2'b11, 10, 0);
   endtask

   task automatic test_alt_ready_toggle();
      drive_burst(2'b10, 4, 1);
   endtask

   task automatic test_len_zero();
      drive_burst(2'b00, 0, 0);
   endtask

   task automatic test_start_during_busy();
      start = 1'b1; mode = 2'b01; len = LEN_W'(3); ready = 1'b1;
      tick();
      mode = 2'b11; len = LEN_W'(7);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (valid !== 1'b1 || data_out !== 8'hFF || last !== (k == 2)) begin
            miscompares++;
            $display("FAIL busy_start_beat k=%0d: valid=%b data=%h last=%b required 1 ff %b",
                     k, valid, data_out, last, (k == 2));
         end
         tick();
      end
      vectors++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_start_done: done=%b valid=%b required 1 0", done, valid);
      end
      tick();
      start = 1'b0; ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_ignored: valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_burst();
      start = 1'b1; mode = 2'b11; len = LEN_W'(5); ready = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({data_out, valid, last, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: data=%h valid=%b last=%b busy=%b done=%b required all 0",
                  data_out, valid, last, busy, done);
      end
      tick(); tick();
      rst = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: done=%b valid=%b busy=%b required 0 0 0", done, valid, busy);
         end
         tick();
      end
      drive_burst(2'b11, 5, 0);
   endtask

   task automatic test_random();
      for (int b = 0; b < 25; b++) begin
         drive_burst(2'($urandom), int'($urandom_range(0, 12)), 2);
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_all_one();
      test_walk();
      test_alt_ready_toggle();
      test_len_zero();
      test_start_during_busy();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_zero_one_pattern_gen

`default_nettype wire
